// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg -- shared definitions for the BRAM port arbiter.
//   arb_state_e : arbiter state (ARB = round-robin, LOCKED = grant held by one owner)
//   DEF_AW/DW/BEW : default BRAM port widths
//   RD_LAT_* : read latency, acceptance to rvalid, for both output-register settings
// Optional feature macro: BRAM_ARB_OUTREG_EN (adds a register on rdata_i).
package bram_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_AW  = 15;
  localparam int DEF_DW  = 18;
  localparam int DEF_BEW = 2;

  localparam int RD_LAT_BASE   = 2;
  localparam int RD_LAT_OUTREG = 3;

`ifdef BRAM_ARB_OUTREG_EN
  localparam int RD_LAT = RD_LAT_OUTREG;
`else
  localparam int RD_LAT = RD_LAT_BASE;
`endif

endpackage

// File: rtl/bram_arb_rr.sv
// bram_arb_rr -- combinational round-robin one-hot picker.
//   req : request vector
//   ptr : index where the search starts (highest priority this cycle)
//   gnt : one-hot grant, first requester found at or after ptr (wrapping); zero if no request
module bram_arb_rr #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic [IW-1:0] idx;

  // Walk from the farthest candidate back towards ptr so the closest one wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % NREQ);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter -- shares one BRAM port between NREQ requesters.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   req_i/we_i/lock_i        : per-requester request, write-not-read, hold-grant
//   addr_i/wdata_i/be_i      : packed per-requester command fields (slice k = requester k)
//   gnt_o                    : one-hot combinational grant; accept = req_i[k] & gnt_o[k]
//   rvalid_o/rdata_o         : per-requester read-return strobe, shared read data
//   ren_o/wen_o/addr_o/wdata_o/be_o : registered BRAM port command
//   rdata_i                  : BRAM read data, valid one cycle after ren_o
// Optional feature macro: BRAM_ARB_OUTREG_EN registers rdata_i once more,
// giving a three-cycle read latency instead of two.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int BEW      = DEF_BEW,
  parameter int LOCK_MAX = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    we_i,
  input  logic [NREQ-1:0]    lock_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  input  logic [NREQ*BEW-1:0] be_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    rvalid_o,
  output logic [DW-1:0]      rdata_o,
  output logic               ren_o,
  output logic               wen_o,
  output logic [AW-1:0]      addr_o,
  output logic [DW-1:0]      wdata_o,
  output logic [BEW-1:0]     be_o,
  input  logic [DW-1:0]      rdata_i
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_e      state_q;
  arb_state_e      state_d;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   rr_ptr_d;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   owner_d;
  logic [CW-1:0]   lock_cnt_q;
  logic [CW-1:0]   lock_cnt_d;

  logic            hold;
  logic [NREQ-1:0] rr_gnt;
  logic [NREQ-1:0] gnt;
  logic            acc;
  logic [IW-1:0]   acc_idx;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [BEW-1:0]  sel_be;

  logic [RD_LAT-1:0] tag_vld;
  logic [IW-1:0]     tag_id [RD_LAT];
  logic [DW-1:0]     rdata_src;

  bram_arb_rr #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req (req_i),
    .ptr (rr_ptr_q),
    .gnt (rr_gnt)
  );

  // The lock only holds while the owner keeps both req and lock up and has
  // budget left; otherwise the round-robin pick applies in the same cycle,
  // so an owner change never costs a bubble.
  assign hold = (state_q == LOCKED) && req_i[owner_q] && lock_i[owner_q]
                && (lock_cnt_q < CW'(LOCK_MAX));

  always_comb begin
    gnt = rr_gnt;
    if (hold) begin
      gnt          = '0;
      gnt[owner_q] = 1'b1;
    end
  end

  // Grants are masked while reset is asserted so every output reads zero.
  assign gnt_o = rst_ni ? gnt : '0;
  assign acc   = |gnt;

  always_comb begin
    acc_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) acc_idx = IW'(i);
    end
  end

  assign sel_we    = we_i[acc_idx];
  assign sel_addr  = addr_i[int'(acc_idx) * AW +: AW];
  assign sel_wdata = wdata_i[int'(acc_idx) * DW +: DW];
  assign sel_be    = be_i[int'(acc_idx) * BEW +: BEW];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    if (acc) begin
      rr_ptr_d = (acc_idx == IW'(NREQ - 1)) ? '0 : acc_idx + 1'b1;
      if (hold) begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end else if (lock_i[acc_idx]) begin
        state_d    = LOCKED;
        owner_d    = acc_idx;
        lock_cnt_d = CW'(1);
      end else begin
        state_d    = ARB;
        lock_cnt_d = '0;
      end
    end else begin
      state_d    = ARB;
      lock_cnt_d = '0;
    end
  end

  // Stage 1: accepted command onto the BRAM port. Address and write data
  // hold when idle; byte enables are only meaningful on writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ren_o   <= 1'b0;
      wen_o   <= 1'b0;
      addr_o  <= '0;
      wdata_o <= '0;
      be_o    <= '0;
    end else begin
      ren_o <= acc & ~sel_we;
      wen_o <= acc & sel_we;
      be_o  <= (acc && sel_we) ? sel_be : '0;
      if (acc) begin
        addr_o  <= sel_addr;
        wdata_o <= sel_wdata;
      end
    end
  end

  // Requester-id tag pipeline, one stage per cycle of read latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_vld[0] <= acc & ~sel_we;
      tag_id[0]  <= acc_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

`ifdef BRAM_ARB_OUTREG_EN
  logic [DW-1:0] rdata_q;

  // Extra read-data stage to ease timing out of the BRAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else         rdata_q <= rdata_i;
  end
  assign rdata_src = rdata_q;
`else
  assign rdata_src = rdata_i;
`endif

  assign rdata_o = tag_vld[RD_LAT-1] ? rdata_src : '0;

  always_comb begin
    rvalid_o = '0;
    if (tag_vld[RD_LAT-1]) rvalid_o[tag_id[RD_LAT-1]] = 1'b1;
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 15;
  localparam int DW   = 18;
  localparam int BEW  = 2;
  localparam int LW   = DW / BEW;
`ifdef BRAM_ARB_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ-1:0]     we = '0;
  logic [NREQ-1:0]     lock = '0;
  logic [NREQ*AW-1:0]  addr = '0;
  logic [NREQ*DW-1:0]  wdata = '0;
  logic [NREQ*BEW-1:0] be = '0;
  logic [NREQ-1:0]     gnt_o;
  logic [NREQ-1:0]     rvalid_o;
  logic [DW-1:0]       rdata_o;
  logic                ren_o;
  logic                wen_o;
  logic [AW-1:0]       addr_o;
  logic [DW-1:0]       wdata_o;
  logic [BEW-1:0]      be_o;
  logic [DW-1:0]       rdata = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } rd_t;
  rd_t rdq[$];

  logic [DW-1:0] bram [int];
  logic [DW-1:0] ref_mem [int];

  logic          exp_ren = 1'b0;
  logic          exp_wen = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic [BEW-1:0] exp_be = '0;

  bram_port_arbiter dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .we_i     (we),
    .lock_i   (lock),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .be_i     (be),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .ren_o    (ren_o),
    .wen_o    (wen_o),
    .addr_o   (addr_o),
    .wdata_o  (wdata_o),
    .be_o     (be_o),
    .rdata_i  (rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BEW-1:0] b);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < BEW; i++) if (b[i]) r[i*LW +: LW] = nw[i*LW +: LW];
    return r;
  endfunction

  // BRAM model: synchronous write with byte enables, one-cycle read.
  always @(posedge clk) begin
    if (wen_o) bram[int'(addr_o)] = merge(bram.exists(int'(addr_o)) ? bram[int'(addr_o)] : '0,
                                          wdata_o, be_o);
    if (ren_o) rdata <= bram.exists(int'(addr_o)) ? bram[int'(addr_o)] : '0;
  end

  // Scoreboard: records accepts, checks the registered command and read returns.
  always @(negedge clk) begin
    logic [NREQ-1:0] oh;
    rd_t e;
    int a;
    cyc++;
    if (!rst_n) begin
      rdq.delete();
      exp_ren = 1'b0;
      exp_wen = 1'b0;
    end else begin
      total++;
      if (ren_o !== exp_ren || wen_o !== exp_wen) begin
        bad++;
        $display("FAIL cmd_strobe cyc=%0d: ren/wen=%b%b expected %b%b", cyc, ren_o, wen_o, exp_ren, exp_wen);
      end
      if (exp_ren || exp_wen) begin
        total++;
        if (addr_o !== exp_addr || be_o !== exp_be || (exp_wen && wdata_o !== exp_wdata)) begin
          bad++;
          $display("FAIL cmd_fields cyc=%0d: addr=%h be=%b wdata=%h expected addr=%h be=%b wdata=%h",
                   cyc, addr_o, be_o, wdata_o, exp_addr, exp_be, exp_wdata);
        end
      end
      if (rvalid_o !== '0) begin
        total++;
        if (rdq.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected cyc=%0d: rvalid=%b rdata=%h expected no return", cyc, rvalid_o, rdata_o);
        end else begin
          e = rdq.pop_front();
          oh = '0;
          oh[e.id] = 1'b1;
          if (rvalid_o !== oh || rdata_o !== e.data || cyc != e.due) begin
            bad++;
            $display("FAIL rd_return cyc=%0d: rvalid=%b rdata=%h expected rvalid=%b rdata=%h at cyc=%0d",
                     cyc, rvalid_o, rdata_o, oh, e.data, e.due);
          end
        end
      end else if (rdq.size() != 0 && rdq[0].due <= cyc) begin
        total++;
        bad++;
        e = rdq.pop_front();
        $display("FAIL rd_missing cyc=%0d: rvalid=0 expected requester %0d data %h", cyc, e.id, e.data);
      end
      total++;
      if ($countones(gnt_o) > 1 || (gnt_o & ~req) != '0 || ((req != '0) != (gnt_o != '0))) begin
        bad++;
        $display("FAIL gnt_onehot cyc=%0d: gnt=%b req=%b expected one-hot grant to a requester", cyc, gnt_o, req);
      end
      exp_ren = 1'b0;
      exp_wen = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        if (gnt_o[k] && req[k]) begin
          a = int'(addr[k*AW +: AW]);
          exp_addr = addr[k*AW +: AW];
          exp_wdata = wdata[k*DW +: DW];
          if (we[k]) begin
            exp_wen = 1'b1;
            exp_be = be[k*BEW +: BEW];
            ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : '0, exp_wdata, exp_be);
          end else begin
            exp_ren = 1'b1;
            exp_be = '0;
            rdq.push_back('{id: k, data: (ref_mem.exists(a) ? ref_mem[a] : '0), due: cyc + LAT});
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int k, input logic w, input logic [AW-1:0] ad,
                         input logic [DW-1:0] wd, input logic [BEW-1:0] b);
    we[k] = w;
    addr[k*AW +: AW] = ad;
    wdata[k*DW +: DW] = wd;
    be[k*BEW +: BEW] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    we = '0;
    lock = '0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    total++;
    if ({gnt_o, rvalid_o, rdata_o, ren_o, wen_o, addr_o, wdata_o, be_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: gnt=%b rvalid=%b rdata=%h ren=%b wen=%b addr=%h wdata=%h be=%b expected all 0",
               gnt_o, rvalid_o, rdata_o, ren_o, wen_o, addr_o, wdata_o, be_o);
    end
    step();
    req = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] e;
    do_reset();
    for (int k = 0; k < NREQ; k++) set_cmd(k, 1'b0, AW'(k + 1), '0, '0);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e = '0;
      e[i % NREQ] = 1'b1;
      total++;
      if (gnt_o !== e) begin
        bad++;
        $display("FAIL rr_grant step %0d: gnt=%b expected %b", i, gnt_o, e);
      end
      if (i > 0) begin
        total++;
        if (ren_o !== 1'b1) begin
          bad++;
          $display("FAIL rr_ren step %0d: ren=%b expected 1", i, ren_o);
        end
      end
      step();
    end
    req = '0;
    @(negedge clk);
    total++;
    if (ren_o !== 1'b1) begin
      bad++;
      $display("FAIL rr_ren step 5: ren=%b expected 1", ren_o);
    end
    repeat (LAT + 1) step();
  endtask

  task automatic test_write_read();
    set_cmd(2, 1'b1, 15'h0010, 18'h3ABCD, 2'b11);
    req = 4'b0100;
    @(negedge clk);
    total++;
    if (gnt_o !== 4'b0100) begin
      bad++;
      $display("FAIL wr_grant: gnt=%b expected 0100", gnt_o);
    end
    step();
    set_cmd(2, 1'b0, 15'h0010, '0, 2'b11);
    @(negedge clk);
    total++;
    if (wen_o !== 1'b1 || gnt_o !== 4'b0100) begin
      bad++;
      $display("FAIL wr_issue: wen=%b gnt=%b expected wen=1 gnt=0100", wen_o, gnt_o);
    end
    step();
    req = '0;
    @(negedge clk);
    total++;
    if (ren_o !== 1'b1 || be_o !== 2'b00) begin
      bad++;
      $display("FAIL rd_issue: ren=%b be=%b expected ren=1 be=00", ren_o, be_o);
    end
    repeat (LAT - 1) @(negedge clk);
    total++;
    if (rvalid_o !== 4'b0100 || rdata_o !== 18'h3ABCD) begin
      bad++;
      $display("FAIL rd_data: rvalid=%b rdata=%h expected 0100 3abcd", rvalid_o, rdata_o);
    end
    repeat (2) step();
  endtask

  task automatic test_lock_max();
    do_reset();
    lock = 4'b0010;
    req = 4'b1110;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      total++;
      if (gnt_o !== ((i < 16) ? 4'b0010 : 4'b0100)) begin
        bad++;
        $display("FAIL lock_max step %0d: gnt=%b expected %b", i, gnt_o, (i < 16) ? 4'b0010 : 4'b0100);
      end
      step();
    end
    req = '0;
    lock = '0;
    repeat (LAT + 1) step();
  endtask

  task automatic test_lock_drop();
    do_reset();
    lock = 4'b0001;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) lock = '0;
      @(negedge clk);
      total++;
      if (gnt_o !== ((i < 3) ? 4'b0001 : 4'b0010)) begin
        bad++;
        $display("FAIL lock_drop step %0d: gnt=%b expected %b", i, gnt_o, (i < 3) ? 4'b0001 : 4'b0010);
      end
      step();
    end
    req = '0;
    repeat (LAT + 1) step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_cmd(0, 1'b0, 15'h0010, '0, '0);
    req = 4'b0001;
    @(negedge clk);
    total++;
    if (gnt_o !== 4'b0001) begin
      bad++;
      $display("FAIL mid_grant: gnt=%b expected 0001", gnt_o);
    end
    step();
    rst_n = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({gnt_o, rvalid_o, rdata_o, ren_o, wen_o, addr_o, wdata_o, be_o} !== '0) begin
        bad++;
        $display("FAIL mid_reset_outputs %0d: gnt=%b rvalid=%b rdata=%h ren=%b wen=%b addr=%h expected all 0",
                 i, gnt_o, rvalid_o, rdata_o, ren_o, wen_o, addr_o);
      end
      step();
    end
    rst_n = 1'b1;
    we = 4'b1010;
    req = 4'b1010;
    @(negedge clk);
    total++;
    if (gnt_o !== 4'b0010) begin
      bad++;
      $display("FAIL mid_first_grant: gnt=%b expected 0010", gnt_o);
    end
    step();
    req = '0;
    we = '0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      total++;
      if (rvalid_o !== '0) begin
        bad++;
        $display("FAIL mid_no_rvalid %0d: rvalid=%b expected 0000", i, rvalid_o);
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        req[k] = ($urandom_range(0, 9) < 6);
        lock[k] = lock[k] ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
        set_cmd(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), BEW'($urandom));
      end
      step();
    end
    req = '0;
    lock = '0;
    repeat (LAT + 3) step();
    total++;
    if (rdq.size() != 0) begin
      bad++;
      $display("FAIL rand_drain: %0d reads outstanding expected 0", rdq.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_read();
    test_lock_max();
    test_lock_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
